// File: rtl/hetszegmens2bin_scan.sv
// hetszegmens2bin_scan
// Recovers hex digit values from a multiplexed, active-high 7-segment bus.
// Each stable {digit_sel, segments} interval yields exactly one capture.
// A capture with a one-hot select decodes the pattern into that digit's slot.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 synchronous reset, active-high
//   input_segments      segment bus, bit6=a .. bit0=g, 1 = lit
//   input_digit_sel     digit enable, one-hot while a digit is shown
//   output_bin          captured nibbles, digit i at [4i+3:4i]
//   output_digit_valid  bit i = last capture of digit i was a legal pattern
//   output_frame        one-cycle pulse when every digit has been captured
//   output_bad_pattern  one-cycle pulse on capture of an undecodable pattern
module hetszegmens2bin_scan #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            input_segments,
    input  logic [DIGITS-1:0]     input_digit_sel,
    output logic [4*DIGITS-1:0]   output_bin,
    output logic [DIGITS-1:0]     output_digit_valid,
    output logic                  output_frame,
    output logic                  output_bad_pattern
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t             state, state_next;
    logic [6:0]         s_seg;
    logic [DIGITS-1:0]  s_sel;
    logic [CNT_W-1:0]   cnt;
    logic [DIGITS-1:0]  seen;
    logic [DIGITS-1:0]  seen_upd;
    logic               same;
    logic               capture;
    logic               sel_onehot;
    logic [4:0]         dec;

    // Returns {legal, nibble}; exact match on all seven segments.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h7E: decode = {1'b1, 4'h0};
            7'h30: decode = {1'b1, 4'h1};
            7'h6D: decode = {1'b1, 4'h2};
            7'h79: decode = {1'b1, 4'h3};
            7'h33: decode = {1'b1, 4'h4};
            7'h5B: decode = {1'b1, 4'h5};
            7'h5F: decode = {1'b1, 4'h6};
            7'h70: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h7B: decode = {1'b1, 4'h9};
            7'h77: decode = {1'b1, 4'hA};
            7'h1F: decode = {1'b1, 4'hB};
            7'h4E: decode = {1'b1, 4'hC};
            7'h3D: decode = {1'b1, 4'hD};
            7'h4F: decode = {1'b1, 4'hE};
            7'h47: decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    assign same       = (input_segments == s_seg) && (input_digit_sel == s_sel);
    assign sel_onehot = (s_sel != '0) && ((s_sel & (s_sel - DIGITS'(1))) == '0);
    assign dec        = decode(s_seg);
    assign seen_upd   = seen | s_sel;

    always_ff @(posedge clk) begin
        if (rst) state <= SETTLE;
        else     state <= state_next;
    end

    // Capture fires once per stable interval: on the edge that would take
    // cnt to STABLE_CYCLES, after which HOLD blocks any repeat.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            SETTLE: begin
                if (same && cnt == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!same) state_next = SETTLE;
            end
            default: state_next = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg              <= '0;
            s_sel              <= '0;
            cnt                <= '0;
            seen               <= '0;
            output_bin         <= '0;
            output_digit_valid <= '0;
            output_frame       <= 1'b0;
            output_bad_pattern <= 1'b0;
        end else begin
            s_seg              <= input_segments;
            s_sel              <= input_digit_sel;
            output_frame       <= 1'b0;
            output_bad_pattern <= 1'b0;

            if (!same)                cnt <= '0;
            else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;

            // Blanking or multi-hot selects are ignored entirely.
            if (capture && sel_onehot) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (s_sel[i]) begin
                        if (dec[4]) begin
                            output_bin[4*i +: 4]  <= dec[3:0];
                            output_digit_valid[i] <= 1'b1;
                        end else begin
                            output_digit_valid[i] <= 1'b0;
                        end
                    end
                end
                if (!dec[4]) output_bad_pattern <= 1'b1;
                if (&seen_upd) begin
                    output_frame <= 1'b1;
                    seen         <= '0;
                end else begin
                    seen <= seen_upd;
                end
            end
        end
    end

endmodule

// File: tb/tb_hetszegmens2bin_scan.sv
module tb_hetszegmens2bin_scan;

    localparam int DIGITS = 4;
    localparam int S      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  input_segments = '0;
    logic [3:0]  input_digit_sel = '0;
    logic [15:0] output_bin;
    logic [3:0]  output_digit_valid;
    logic        output_frame;
    logic        output_bad_pattern;

    hetszegmens2bin_scan #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_segments     (input_segments),
        .input_digit_sel    (input_digit_sel),
        .output_bin         (output_bin),
        .output_digit_valid (output_digit_valid),
        .output_frame       (output_frame),
        .output_bad_pattern (output_bad_pattern)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [3:0]  valid;
        logic        frame;
        logic        bad;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int frame_cnt = 0;
    int bad_cnt   = 0;

    // Reference model state: run length of the current raw value.
    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_bin;
    logic [3:0]  m_valid, m_seen;
    logic        m_frame, m_bad;

    logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic [3:0] sel, input logic [6:0] seg);
        int idx;
        int nib;
        idx = -1;
        nib = -1;
        if (r) begin
            m_prev = '0; m_run = 1;
            m_bin = '0; m_valid = '0; m_seen = '0; m_frame = 0; m_bad = 0;
            return;
        end
        m_frame = 0;
        m_bad   = 0;
        if ({sel, seg} != m_prev) begin
            m_prev = {sel, seg};
            m_run  = 1;
        end else if (m_run < 1000) begin
            m_run++;
        end
        if (m_run == S + 1 && $countones(sel) == 1) begin
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            for (int j = 0; j < 16; j++) if (lut[j] == seg) nib = j;
            if (nib >= 0) begin
                m_bin[4*idx +: 4] = nib[3:0];
                m_valid[idx] = 1'b1;
            end else begin
                m_valid[idx] = 1'b0;
                m_bad = 1'b1;
            end
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                m_frame = 1'b1;
                m_seen  = '0;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] sel, input logic [6:0] seg, input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            rst = r;
            input_digit_sel = sel;
            input_segments  = seg;
            model(r, sel, seg);
            e.bin = m_bin; e.valid = m_valid; e.frame = m_frame; e.bad = m_bad;
            q.push_back(e);
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (output_frame === 1'b1) frame_cnt++;
            if (output_bad_pattern === 1'b1) bad_cnt++;
            chk("bin",   32'(output_bin),         32'(e.bin));
            chk("valid", 32'(output_digit_valid), 32'(e.valid));
            chk("frame", 32'(output_frame),       32'(e.frame));
            chk("bad",   32'(output_bad_pattern), 32'(e.bad));
        end
    endtask

    initial begin
        // Reset
        cyc(1, 4'b0000, 7'h00, 2);
        chk("reset_bin",   32'(output_bin), 32'h0);
        chk("reset_valid", 32'(output_digit_valid), 32'h0);

        // Test 1: single digit, latency
        cyc(0, 4'b0001, 7'h7E, S);
        chk("t1_early_valid", 32'(output_digit_valid), 32'h0);
        cyc(0, 4'b0001, 7'h7E, 1);
        chk("t1_valid", 32'(output_digit_valid), 32'h1);
        chk("t1_nib",   32'(output_bin[3:0]), 32'h0);
        chk("t1_nobad", 32'(bad_cnt), 32'd0);

        // Test 2: glitch restarts the count
        cyc(0, 4'b0001, 7'h30, 2);
        cyc(0, 4'b0001, 7'h7F, 1);
        cyc(0, 4'b0001, 7'h30, S);
        chk("t2_not_yet", 32'(output_bin[3:0]), 32'h0);
        cyc(0, 4'b0001, 7'h30, 2);
        chk("t2_nib", 32'(output_bin[3:0]), 32'h1);

        // Test 3: full frame after fresh reset
        cyc(1, 4'b0000, 7'h00, 1);
        frame_cnt = 0;
        cyc(0, 4'b0001, 7'h5B, 6);
        cyc(0, 4'b0010, 7'h33, 6);
        cyc(0, 4'b0100, 7'h79, 6);
        cyc(0, 4'b1000, 7'h7E, S);
        chk("t3_no_early_frame", 32'(frame_cnt), 32'd0);
        cyc(0, 4'b1000, 7'h7E, 1);
        chk("t3_frame_edge", 32'(output_frame), 32'h1);
        cyc(0, 4'b1000, 7'h7E, 1);
        chk("t3_bin",    32'(output_bin), 32'h0345);
        chk("t3_valid",  32'(output_digit_valid), 32'hF);
        chk("t3_frames", 32'(frame_cnt), 32'd1);

        // Test 4: invalid pattern on digit 2
        bad_cnt = 0;
        cyc(0, 4'b0100, 7'h01, 8);
        chk("t4_bad_once", 32'(bad_cnt), 32'd1);
        chk("t4_valid2",   32'(output_digit_valid[2]), 32'h0);
        chk("t4_nib2",     32'(output_bin[11:8]), 32'h3);

        // Test 5: multi-hot and blank selects are ignored
        frame_cnt = 0;
        bad_cnt = 0;
        cyc(0, 4'b0011, 7'h7F, 10);
        cyc(0, 4'b0000, 7'h00, 10);
        cyc(0, 4'b0001, 7'h70, 6);
        cyc(0, 4'b0010, 7'h4E, 6);
        chk("t5_no_frame", 32'(frame_cnt), 32'd0);
        chk("t5_no_bad",   32'(bad_cnt), 32'd0);
        chk("t5_bin",      32'(output_bin), 32'h03C7);
        cyc(0, 4'b1000, 7'h3D, 6);
        chk("t5_frame_now", 32'(frame_cnt), 32'd1);

        // Test 6: reset mid-settle
        cyc(0, 4'b0010, 7'h6D, 2);
        cyc(1, 4'b0010, 7'h6D, 1);
        chk("t6_rst_bin",   32'(output_bin), 32'h0);
        chk("t6_rst_valid", 32'(output_digit_valid), 32'h0);
        cyc(0, 4'b0010, 7'h6D, S);
        chk("t6_no_capture", 32'(output_digit_valid), 32'h0);
        cyc(0, 4'b0010, 7'h6D, 2);
        chk("t6_nib",   32'(output_bin[7:4]), 32'h2);
        chk("t6_valid", 32'(output_digit_valid), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
